min_max_tracker: RTL and testbench

MIN_MAX_TRACKER -- requirements
Module: min_max_tracker

---
 rtl/min_max_tracker_if.sv | 28 ++
 rtl/min_max_tracker.sv | 93 +++++++++
 tb/tb_min_max_tracker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/min_max_tracker_if.sv
// Stream handshake bundle for the min/max tracker: a sample stream in, one
// frame summary (min, max, count) out.
interface min_max_tracker_if #(
  parameter int N  = 32,
  parameter int CW = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_min;
  logic signed [N-1:0] out_max;
  logic [CW-1:0]       out_count;

  // Producer of samples and consumer of results
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count
  );

  // The tracker itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count
  );
endinterface

// File: rtl/min_max_tracker.sv
// Frame min/max tracker: accumulates the signed minimum, maximum and a
// saturating sample count over a frame delimited by in_last, then presents
// the result and stalls the input until the result is consumed.
module min_max_tracker #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input logic              clk,
  input logic              rst,
  min_max_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    ACCUM,
    HOLD
  } state_e;

  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [CW-1:0] COUNT_MAX = '1;

  state_e              state_q, state_d;
  logic signed [N-1:0] min_q, min_d;
  logic signed [N-1:0] max_q, max_d;
  logic [CW-1:0]       count_q, count_d;
  logic                accept;

  // Handshake flags come from state alone; outputs mirror the running registers
  always_comb begin
    bus.in_ready  = (state_q != HOLD);
    bus.out_valid = (state_q == HOLD);
    bus.out_min   = min_q;
    bus.out_max   = max_q;
    bus.out_count = count_q;
    accept        = bus.in_valid && (state_q != HOLD);
  end

  // Next-state and accumulator update; signed compares against the registered extremes
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          min_d   = bus.in_data;
          max_d   = bus.in_data;
          count_d = COUNT_ONE;
          state_d = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if ($signed(bus.in_data) < $signed(min_q)) begin
            min_d = bus.in_data;
          end
          if ($signed(max_q) < $signed(bus.in_data)) begin
            max_d = bus.in_data;
          end
          if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_ONE;
          end
          if (bus.in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and accumulator registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      min_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_min_max_tracker.sv
// Bench for min_max_tracker: two instances (CW=16 and CW=2, both N=8) share
// one stimulus stream; frame results are queued when the last sample is
// driven and compared when the result handshake is reached.
module tb_min_max_tracker;

  typedef struct packed {
    logic signed [7:0] data;
    logic              last;
    logic [2:0]        stall;
    logic signed [7:0] emin;
    logic signed [7:0] emax;
    logic [15:0]       ecnt;
    logic [1:0]        ecnt2;
  } vec_t;

  typedef struct packed {
    logic signed [7:0] mn;
    logic signed [7:0] mx;
    logic [15:0]       cnt;
    logic [1:0]        cnt2;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  min_max_tracker_if #(.N(8), .CW(16)) bus_a ();
  min_max_tracker_if #(.N(8), .CW(2))  bus_b ();

  min_max_tracker #(.N(8), .CW(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  min_max_tracker #(.N(8), .CW(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  // Free-running clock, period 10
  always #5 clk = ~clk;

  function automatic vec_t mk(input int d, input bit l, input int st,
                              input int mn, input int mx, input int c, input int c2);
    vec_t v;
    v.data  = 8'(d);
    v.last  = l;
    v.stall = 3'(st);
    v.emin  = 8'(mn);
    v.emax  = 8'(mx);
    v.ecnt  = 16'(c);
    v.ecnt2 = 2'(c2);
    return v;
  endfunction

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    bus_a.in_valid = v;
    bus_b.in_valid = v;
    bus_a.in_data  = d;
    bus_b.in_data  = d;
    bus_a.in_last  = l;
    bus_b.in_last  = l;
  endtask

  task automatic set_out_ready(input logic r);
    bus_a.out_ready = r;
    bus_b.out_ready = r;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_out_valid"}, bus_a.out_valid, 0);
    check_output({tag, "_in_ready"},  bus_a.in_ready, 1);
    check_output({tag, "_min"},       bus_a.out_min, 0);
    check_output({tag, "_max"},       bus_a.out_max, 0);
    check_output({tag, "_count"},     bus_a.out_count, 0);
    check_output({tag, "_count2"},    bus_b.out_count, 0);
  endtask

  // Drive one sample, which must be accepted on the next edge
  task automatic apply_stimulus(input int d, input bit last, input int mn,
                                input int mx, input int c, input int c2);
    exp_t e;
    drive(1'b1, 8'(d), last);
    check_output("in_ready_accum", bus_a.in_ready, 1);
    if (last) begin
      e.mn   = 8'(mn);
      e.mx   = 8'(mx);
      e.cnt  = 16'(c);
      e.cnt2 = 2'(c2);
      exp_q.push_back(e);
    end
    tick();
    drive(1'b0, 8'($urandom), 1'($urandom));
  endtask

  // Result side: latency check, optional stall in HOLD, then the handshake
  task automatic drain(input int stall);
    exp_t e;
    check_output("latency_out_valid", bus_a.out_valid, 1);
    check_output("latency_out_valid2", bus_b.out_valid, 1);
    if (exp_q.size() == 0) begin
      check_output("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    for (int k = 0; k < stall; k++) begin
      drive(1'b1, 8'h63, 1'b1);
      set_out_ready(1'b0);
      check_output("hold_in_ready", bus_a.in_ready, 0);
      check_output("hold_out_valid", bus_a.out_valid, 1);
      check_output("hold_count", bus_a.out_count, e.cnt);
      check_output("hold_min", $signed(bus_a.out_min), $signed(e.mn));
      tick();
    end
    check_output("min",    $signed(bus_a.out_min), $signed(e.mn));
    check_output("max",    $signed(bus_a.out_max), $signed(e.mx));
    check_output("count",  bus_a.out_count, e.cnt);
    check_output("min2",   $signed(bus_b.out_min), $signed(e.mn));
    check_output("max2",   $signed(bus_b.out_max), $signed(e.mx));
    check_output("count2", bus_b.out_count, e.cnt2);
    set_out_ready(1'b1);
    tick();
    check_output("post_hs_out_valid", bus_a.out_valid, 0);
    check_output("post_hs_in_ready",  bus_a.in_ready, 1);
    check_output("post_hs_count",     bus_a.out_count, e.cnt);
    set_out_ready(1'b0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  // Main sequence: reset, table of frames, corner sequences, random frames
  initial begin
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    set_out_ready(1'b0);
    #2;
    check_reset_state("reset");

    vecs.push_back(mk(42, 1, 0, 42, 42, 1, 1));
    vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(-3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, -3, 7, 4, 3));
    vecs.push_back(mk(-128, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(127, 1, 0, -128, 127, 2, 2));
    vecs.push_back(mk(127, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(-128, 1, 0, -128, 127, 2, 2));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(-50, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(9, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(-50, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, -50, 9, 6, 3));
    vecs.push_back(mk(7, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 1, 0, 7, 7, 3, 3));
    vecs.push_back(mk(-100, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(-5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(-100, 1, 2, -100, -5, 3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(-1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, -1, 1, 3, 3));

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i % 2 == 1) begin
        drive(1'b0, 8'($urandom), 1'b1);
        tick();
      end
      apply_stimulus(vecs[i].data, vecs[i].last, vecs[i].emin, vecs[i].emax,
                     vecs[i].ecnt, vecs[i].ecnt2);
      if (vecs[i].last) begin
        drain(int'(vecs[i].stall));
      end
    end

    // Reset while a result is pending drops it without a handshake
    apply_stimulus(33, 1, 33, 33, 1, 1);
    check_output("hold_before_reset", bus_a.out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("reset_in_hold");
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-frame after three samples, then a fresh frame
    apply_stimulus(10, 0, 0, 0, 0, 0);
    apply_stimulus(-20, 0, 0, 0, 0, 0);
    apply_stimulus(30, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    check_reset_state("reset_mid_frame");
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(2, 1, 1, 2, 2, 2);
    drain(0);

    // Random frames against a small reference model
    for (int f = 0; f < 4; f++) begin
      int len;
      int mn;
      int mx;
      len = $urandom_range(1, 9);
      mn  = 0;
      mx  = 0;
      for (int j = 0; j < len; j++) begin
        logic [7:0] r;
        int dv;
        r  = 8'($urandom);
        dv = $signed(r);
        if (j == 0) begin
          mn = dv;
          mx = dv;
        end else begin
          if (dv < mn) mn = dv;
          if (dv > mx) mx = dv;
        end
        apply_stimulus(dv, (j == len - 1), mn, mx, j + 1, (j + 1 > 3) ? 3 : j + 1);
      end
      drain(f % 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
